fft_frame_feeder: RTL and testbench

FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

---
 rtl/fft_frame_feeder.sv | 193 +++++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: buffers one frame of audio samples, then streams it to an
// AXI4-Stream FFT core (one config beat, FFT_LEN data beats) and waits for the
// FFT result burst to finish before refilling.
// Optional feature: define FFT_FEEDER_DC_REMOVE_EN to subtract the frame mean
// from every streamed sample (saturated to 16-bit signed).
module fft_frame_feeder #(
    parameter int unsigned FFT_LEN    = 1024,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  audio_valid,
    input  logic [DATA_WIDTH-1:0] audio_data,
    output logic                  xn_axi4s_cfg_tvalid,
    output logic                  xn_axi4s_cfg_tdata,
    output logic                  xn_axi4s_data_tvalid,
    output logic [31:0]           xn_axi4s_data_tdata,
    output logic                  xn_axi4s_data_tlast,
    input  logic                  xn_axi4s_data_tready,
    input  logic                  xk_axi4s_data_tvalid,
    output logic [5:0]            frame_cnt,
    output logic [15:0]           overrun_cnt
);

    localparam int unsigned AW = $clog2(FFT_LEN);
    localparam logic [AW-1:0] LastIdx = AW'(FFT_LEN - 1);

    typedef enum logic [2:0] {StIdle, StFill, StCfg, StSend, StWait} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic [15:0]     real_q, real_d;
    logic [5:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]     overrun_q, overrun_d;
    logic            xk_prev_q;
    logic            xk_seen_q, xk_seen_d;

    logic signed [DATA_WIDTH-1:0] buf_mem [FFT_LEN];
    logic signed [DATA_WIDTH-1:0] rd_sample;
    logic [15:0]                  out_sample;
    logic                         wr_en;

    assign wr_en     = (state_q == StFill) && audio_valid;
    assign rd_sample = buf_mem[rd_ptr_q];

    // Frame buffer; contents deliberately not reset, every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_ptr_q] <= audio_data;
        end
    end

`ifdef FFT_FEEDER_DC_REMOVE_EN
    logic signed [25:0] sum_q, sum_d;
    logic signed [25:0] mean_q, mean_d;
    logic signed [26:0] diff;

    // Frame sum accumulates in FILL; mean is latched in CFG for the whole SEND.
    always_comb begin
        sum_d  = sum_q;
        mean_d = mean_q;
        if (state_d == StFill && state_q != StFill) begin
            sum_d = '0;
        end else if (wr_en) begin
            sum_d = sum_q + 26'($signed(audio_data));
        end
        if (state_q == StCfg) begin
            mean_d = sum_q >>> AW;
        end
    end

    // Mean-removed sample, clipped to the 16-bit signed range.
    always_comb begin
        diff = 27'(rd_sample) - 27'(mean_q);
        if (diff > 27'sd32767) begin
            out_sample = 16'h7FFF;
        end else if (diff < -27'sd32768) begin
            out_sample = 16'h8000;
        end else begin
            out_sample = diff[15:0];
        end
    end

    // Accumulator and latched mean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            mean_q <= '0;
        end else begin
            sum_q  <= sum_d;
            mean_q <= mean_d;
        end
    end
`else
    assign out_sample = 16'(rd_sample);
`endif

    // Next-state logic: fill, config beat, stream with backpressure, wait for result burst.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        real_d      = real_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        xk_seen_d   = xk_seen_q;

        if (audio_valid && state_q != StFill && overrun_q != 16'hFFFF) begin
            overrun_d = overrun_q + 16'd1;
        end

        unique case (state_q)
            StIdle: state_d = StFill;
            StFill: begin
                if (audio_valid) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == LastIdx) begin
                        wr_ptr_d = '0;
                        state_d  = StCfg;
                    end
                end
            end
            StCfg: state_d = StSend;
            StSend: begin
                // Load the next beat when the output slot is empty or being drained.
                if (!tvalid_q || (xn_axi4s_data_tready && !tlast_q)) begin
                    tvalid_d = 1'b1;
                    real_d   = out_sample;
                    tlast_d  = (rd_ptr_q == LastIdx);
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end else if (xn_axi4s_data_tready) begin
                    tvalid_d  = 1'b0;
                    tlast_d   = 1'b0;
                    real_d    = '0;
                    xk_seen_d = 1'b0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (xk_axi4s_data_tvalid && !xk_prev_q) begin
                    xk_seen_d = 1'b1;
                end
                if (!xk_axi4s_data_tvalid && xk_prev_q && xk_seen_q) begin
                    xk_seen_d   = 1'b0;
                    frame_cnt_d = frame_cnt_q + 6'd1;
                    state_d     = StFill;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            real_q      <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= '0;
            xk_prev_q   <= 1'b0;
            xk_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            real_q      <= real_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            xk_prev_q   <= xk_axi4s_data_tvalid;
            xk_seen_q   <= xk_seen_d;
        end
    end

    assign xn_axi4s_cfg_tvalid  = (state_q == StCfg);
    assign xn_axi4s_cfg_tdata   = 1'b1;
    assign xn_axi4s_data_tvalid = tvalid_q;
    assign xn_axi4s_data_tdata  = {16'h0000, real_q};
    assign xn_axi4s_data_tlast  = tlast_q;
    assign frame_cnt            = frame_cnt_q;
    assign overrun_cnt          = overrun_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed self-checking bench for fft_frame_feeder, run with a 64-sample frame
// so that the 64-frame counter wrap stays short.
module tb_fft_frame_feeder;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        audio_valid = 1'b0;
    logic [15:0] audio_data = '0;
    logic        cfg_tvalid, cfg_tdata;
    logic        tvalid, tlast;
    logic [31:0] tdata;
    logic        tready = 1'b0;
    logic        xk_tvalid = 1'b0;
    logic [5:0]  frame_cnt;
    logic [15:0] overrun_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] in_data  [N];
    logic [15:0] exp_data [N];

    fft_frame_feeder #(
        .FFT_LEN    (N),
        .DATA_WIDTH (16)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .audio_valid          (audio_valid),
        .audio_data           (audio_data),
        .xn_axi4s_cfg_tvalid  (cfg_tvalid),
        .xn_axi4s_cfg_tdata   (cfg_tdata),
        .xn_axi4s_data_tvalid (tvalid),
        .xn_axi4s_data_tdata  (tdata),
        .xn_axi4s_data_tlast  (tlast),
        .xn_axi4s_data_tready (tready),
        .xk_axi4s_data_tvalid (xk_tvalid),
        .frame_cnt            (frame_cnt),
        .overrun_cnt          (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Builds the input frame and its hand-derived expected output.
    task automatic load_frame(input int kind, input int f);
        logic [15:0] v;
        logic [15:0] e;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: v = 16'(i);
                1: v = 16'(i * 1237) ^ 16'h5A5A;
                2: v = 16'hF000 + 16'(N - 1 - i);
                3: v = 16'hAAAA + 16'(i);
                4: v = 16'(i * 3 + 7);
                5: v = 16'(f * 256 + i);
                6: v = 16'd1000;
                7: v = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
                8: v = (i == 0) ? 16'h7FFF : 16'h8000;
                default: v = (i == 0) ? 16'h8000 : 16'h7FFF;
            endcase
            case (kind)
                6: e = 16'h0000;                              // mean 1000
                7: e = (i % 2 == 0) ? 16'h7FFF : 16'h8001;    // mean -1
                8: e = (i == 0) ? 16'h7FFF : 16'hFC01;        // mean -31745
                9: e = (i == 0) ? 16'h8000 : 16'h0400;        // mean 31743
                default: e = v;
            endcase
            in_data[i]  = v;
            exp_data[i] = e;
        end
    endtask

    task automatic fill(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            audio_valid = 1'b1;
            audio_data  = in_data[i];
            tick();
        end
        audio_valid = 1'b0;
    endtask

    task automatic check_cfg();
        check("cfg_tvalid", 32'(cfg_tvalid), 32'd1);
        check("cfg_tdata", 32'(cfg_tdata), 32'd1);
        check("tvalid_in_cfg", 32'(tvalid), 32'd0);
    endtask

    // Entered at the CFG cycle; drains the frame with the chosen tready pattern.
    task automatic send(input int rdy_mode, input int n_junk, input int abort_at);
        int          idx = 0;
        int          cyc = 0;
        int          junk = 0;
        logic        stall = 1'b0;
        logic        seen = 1'b0;
        logic        rdy;
        logic [31:0] held = '0;
        while (idx < N && cyc < 20 * N) begin
            if (idx == abort_at) break;
            if (cyc == 1) check("cfg_one_cycle", 32'(cfg_tvalid), 32'd0);
            if (tvalid && !seen) begin
                seen = 1'b1;
                check("first_beat_latency", 32'(cyc <= 2), 32'd1);
            end
            if (stall) begin
                check("stall_tvalid", 32'(tvalid), 32'd1);
                check("stall_tdata", tdata, held);
            end
            case (rdy_mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = (cyc % 2 == 1);
            endcase
            tready = rdy;
            if (junk < n_junk) begin
                audio_valid = 1'b1;
                audio_data  = 16'hDEAD;
                junk++;
            end else begin
                audio_valid = 1'b0;
            end
            if (tvalid && rdy) begin
                check($sformatf("beat%0d_data", idx), tdata, {16'h0000, exp_data[idx]});
                check($sformatf("beat%0d_tlast", idx), 32'(tlast), 32'(idx == N - 1));
                idx++;
                stall = 1'b0;
            end else begin
                stall = tvalid;
                held  = tdata;
            end
            tick();
            cyc++;
        end
        audio_valid = 1'b0;
        tready      = 1'b0;
        if (abort_at >= N) begin
            check("beats_done", 32'(idx), 32'(N));
            check("tvalid_after_last", 32'(tvalid), 32'd0);
        end
    endtask

    // Entered in WAIT; plays an FFT result burst and checks the frame counter.
    task automatic finish_wait(input int n_junk, input int exp_prev, input int exp_cnt);
        int hi;
        hi = (n_junk > 8) ? n_junk : 8;
        check("wait_tvalid", 32'(tvalid), 32'd0);
        check("wait_cfg", 32'(cfg_tvalid), 32'd0);
        for (int k = 0; k < hi; k++) begin
            xk_tvalid   = 1'b1;
            audio_valid = (k < n_junk);
            audio_data  = 16'hBEEF;
            tick();
        end
        audio_valid = 1'b0;
        check("frame_cnt_before_fall", 32'(frame_cnt), 32'(exp_prev));
        xk_tvalid = 1'b0;
        tick();
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    endtask

    task automatic do_frame(input int kind, input int f, input int rdy_mode, input int send_junk,
                            input int wait_junk, input int exp_prev, input int exp_cnt);
        load_frame(kind, f);
        fill(0, N);
        check_cfg();
        send(rdy_mode, send_junk, N);
        finish_wait(wait_junk, exp_prev, exp_cnt);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_cfg_tvalid", 32'(cfg_tvalid), 32'd0);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

`ifdef FFT_FEEDER_DC_REMOVE_EN
        do_frame(6, 0, 0, 0, 0, 0, 1);
        do_frame(7, 0, 1, 0, 0, 1, 2);
        do_frame(8, 0, 0, 0, 0, 2, 3);
        do_frame(9, 0, 2, 0, 0, 3, 4);
`else
        // Ramp with tready always high.
        do_frame(0, 0, 0, 0, 0, 0, 1);
        check("no_overrun_in_fill", 32'(overrun_cnt), 32'd0);
        // 1,0,0,1 backpressure plus 40 drops in CFG/SEND and 60 in WAIT.
        do_frame(1, 0, 1, 40, 60, 1, 2);
        check("overrun_100", 32'(overrun_cnt), 32'd100);
        // Next frame must hold only FILL samples.
        do_frame(2, 0, 2, 0, 0, 2, 3);
        check("overrun_hold", 32'(overrun_cnt), 32'd100);

        // Reset in the middle of SEND.
        load_frame(3, 0);
        fill(0, N);
        check_cfg();
        send(0, 0, N / 2);
        rst_n = 1'b0;
        #1;
        check("abort_tvalid", 32'(tvalid), 32'd0);
        check("abort_tlast", 32'(tlast), 32'd0);
        check("abort_tdata", tdata, 32'd0);
        check("abort_cfg", 32'(cfg_tvalid), 32'd0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        check("abort_overrun", 32'(overrun_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        load_frame(4, 0);
        fill(0, N - 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("partial_no_cfg", 32'(cfg_tvalid), 32'd0);
            check("partial_no_tvalid", 32'(tvalid), 32'd0);
        end
        fill(N - 1, N);
        check_cfg();
        send(0, 0, N);
        finish_wait(0, 0, 1);

        // Run on to 64 completed frames; the counter wraps to 0.
        for (int f = 2; f <= 64; f++) begin
            do_frame(5, f, f % 3, 0, 0, (f - 1) % 64, f % 64);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
